// File: rtl/e203_dtcm_ram_arbiter.sv
// e203_dtcm_ram_arbiter
// Shares the single-port DTCM SRAM between the core LSU (requester 0) and the
// external ICB slave port (requester 1). Round-robin on ties, one command
// outstanding at a time, one response per command. A hold register keeps SRAM
// read data alive while a response is stalled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing outstanding, any requester may be granted
// ST_RSP  | one response outstanding for owner_q; a new command is only
//         | taken in the same cycle the outstanding response hands off

module e203_dtcm_ram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic          req0_read_i,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_wdata_i,
    input  logic [MW-1:0] req0_wmask_i,

    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic          req1_read_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_wdata_i,
    input  logic [MW-1:0] req1_wmask_i,

    output logic          rsp0_valid_o,
    input  logic          rsp0_ready_i,
    output logic [DW-1:0] rsp0_rdata_o,

    output logic          rsp1_valid_o,
    input  logic          rsp1_ready_i,
    output logic [DW-1:0] rsp1_rdata_o,

    output logic          ram_cs_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [MW-1:0] ram_wem_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          is_read_q, is_read_d;
    logic          first_q, first_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          rr_last_q, rr_last_d;

    logic          rsp_hs;
    logic          can_accept;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic [DW-1:0] rsp_data;

    // The owner's response is taken this cycle, which frees the slot.
    assign rsp_hs     = (state_q == ST_RSP) &&
                        (owner_q ? rsp1_ready_i : rsp0_ready_i);
    assign can_accept = (state_q == ST_IDLE) || rsp_hs;

    // On a tie the requester that did not win last time goes first.
    assign grant1 = req1_valid_i && (!req0_valid_i || !rr_last_q);
    assign grant0 = req0_valid_i && !grant1;

    assign req0_ready_o = grant0 && can_accept;
    assign req1_ready_o = grant1 && can_accept;
    assign accept       = req0_ready_o || req1_ready_o;

    // Live SRAM data on the first response cycle, held copy afterwards.
    assign rsp_data = !is_read_q ? '0 : (first_q ? ram_dout_i : hold_q);

    // Next-state, response outputs and RAM access drive.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        is_read_d = is_read_q;
        first_d   = first_q;
        hold_d    = hold_q;
        rr_last_d = rr_last_q;

        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp0_rdata_o = '0;
        rsp1_rdata_o = '0;

        ram_cs_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_wem_o  = '0;
        ram_din_o  = '0;

        if (state_q == ST_RSP) begin
            if (owner_q) begin
                rsp1_valid_o = 1'b1;
                rsp1_rdata_o = rsp_data;
            end else begin
                rsp0_valid_o = 1'b1;
                rsp0_rdata_o = rsp_data;
            end
            // ram_dout is only valid for one cycle, so always keep a copy.
            if (first_q && is_read_q) begin
                hold_d = ram_dout_i;
            end
            first_d = 1'b0;
            if (rsp_hs) begin
                state_d = ST_IDLE;
            end
        end

        if (accept) begin
            ram_cs_o  = 1'b1;
            state_d   = ST_RSP;
            owner_d   = grant1;
            first_d   = 1'b1;
            rr_last_d = grant1;
            if (grant1) begin
                is_read_d  = req1_read_i;
                ram_addr_o = req1_addr_i;
                ram_we_o   = !req1_read_i;
                ram_wem_o  = req1_read_i ? '0 : req1_wmask_i;
                ram_din_o  = req1_read_i ? '0 : req1_wdata_i;
            end else begin
                is_read_d  = req0_read_i;
                ram_addr_o = req0_addr_i;
                ram_we_o   = !req0_read_i;
                ram_wem_o  = req0_read_i ? '0 : req0_wmask_i;
                ram_din_o  = req0_read_i ? '0 : req0_wdata_i;
            end
        end
    end

    // State register; rr_last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            is_read_q <= 1'b0;
            first_q   <= 1'b0;
            hold_q    <= '0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            is_read_q <= is_read_d;
            first_q   <= first_d;
            hold_q    <= hold_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_ram_arbiter.sv
// Directed bench for e203_dtcm_ram_arbiter with a 1-cycle-latency SRAM model.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the falling edge.

module tb_e203_dtcm_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          req0_valid_i, req0_ready_o, req0_read_i;
    logic [AW-1:0] req0_addr_i;
    logic [DW-1:0] req0_wdata_i;
    logic [MW-1:0] req0_wmask_i;
    logic          req1_valid_i, req1_ready_o, req1_read_i;
    logic [AW-1:0] req1_addr_i;
    logic [DW-1:0] req1_wdata_i;
    logic [MW-1:0] req1_wmask_i;
    logic          rsp0_valid_o, rsp0_ready_i;
    logic [DW-1:0] rsp0_rdata_o;
    logic          rsp1_valid_o, rsp1_ready_i;
    logic [DW-1:0] rsp1_rdata_o;
    logic          ram_cs_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [MW-1:0] ram_wem_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout_i;

    int n_vec = 0;
    int n_err = 0;
    int cs_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    e203_dtcm_ram_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_read_i  (req0_read_i),
        .req0_addr_i  (req0_addr_i),
        .req0_wdata_i (req0_wdata_i),
        .req0_wmask_i (req0_wmask_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_read_i  (req1_read_i),
        .req1_addr_i  (req1_addr_i),
        .req1_wdata_i (req1_wdata_i),
        .req1_wmask_i (req1_wmask_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp0_rdata_o (rsp0_rdata_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp1_ready_i (rsp1_ready_i),
        .rsp1_rdata_o (rsp1_rdata_o),
        .ram_cs_o     (ram_cs_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wem_o    (ram_wem_o),
        .ram_din_o    (ram_din_o),
        .ram_dout_i   (ram_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: dout is garbage on any cycle without a read, so a stalled
    // response must come from the arbiter's hold register.
    always @(posedge clk) begin
        if (ram_cs_o && !ram_we_o) ram_dout_i <= mem[ram_addr_o];
        else                       ram_dout_i <= 32'hA5A5_A5A5;
        if (ram_cs_o && ram_we_o) begin
            for (int b = 0; b < MW; b++)
                if (ram_wem_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
        end
        if (ram_cs_o) cs_cnt <= cs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 1'b0; req0_read_i = 1'b0; req0_addr_i = '0;
        req0_wdata_i = '0;   req0_wmask_i = '0;
        req1_valid_i = 1'b0; req1_read_i = 1'b0; req1_addr_i = '0;
        req1_wdata_i = '0;   req1_wmask_i = '0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Single requester-0 access with immediate response acceptance.
    task automatic acc0(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, output logic v, output logic [DW-1:0] q);
        req0_valid_i = 1'b1; req0_read_i = rd; req0_addr_i = a;
        req0_wdata_i = d;    req0_wmask_i = m; rsp0_ready_i = 1'b1;
        next_cycle();
        req0_valid_i = 1'b0;
        @(negedge clk);
        v = rsp0_valid_o;
        q = rsp0_rdata_o;
        next_cycle();
    endtask

    logic          v;
    logic [DW-1:0] q;
    int            cs_start;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst_rsp0_valid", 32'(rsp0_valid_o), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid_o), 32'd0);
        check("rst_ram_cs",     32'(ram_cs_o),     32'd0);
        do_reset();

        // write then read addr 5 via req0, back to back
        @(negedge clk);
        check("idle_rdata0", rsp0_rdata_o, 32'd0);
        check("idle_ram_addr", 32'(ram_addr_o), 32'd0);
        next_cycle();
        cs_start = cs_cnt;
        req0_valid_i = 1'b1; req0_read_i = 1'b0; req0_addr_i = 13'd5;
        req0_wdata_i = 32'hDEAD_BEEF; req0_wmask_i = 4'hF; rsp0_ready_i = 1'b1;
        @(negedge clk);
        check("wr_ready0", 32'(req0_ready_o), 32'd1);
        check("wr_ram_we", 32'(ram_we_o), 32'd1);
        check("wr_ram_wem", 32'(ram_wem_o), 32'hF);
        check("wr_ram_din", ram_din_o, 32'hDEAD_BEEF);
        next_cycle();
        req0_read_i = 1'b1; req0_wdata_i = '0; req0_wmask_i = '0;
        @(negedge clk);
        check("wr_rsp_valid", 32'(rsp0_valid_o), 32'd1);
        check("wr_rsp_rdata", rsp0_rdata_o, 32'd0);
        check("rd_b2b_ready0", 32'(req0_ready_o), 32'd1);
        check("rd_ram_we", 32'(ram_we_o), 32'd0);
        check("rd_ram_wem", 32'(ram_wem_o), 32'd0);
        next_cycle();
        req0_valid_i = 1'b0;
        @(negedge clk);
        check("rd_rsp_valid", 32'(rsp0_valid_o), 32'd1);
        check("rd_rsp_rdata", rsp0_rdata_o, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk);
        check("rd_rsp_done", 32'(rsp0_valid_o), 32'd0);
        check("cs_count_2", 32'(cs_cnt - cs_start), 32'd2);
        next_cycle();

        // seed data for later tests
        acc0(1'b0, 13'd10, 32'hA0A0_A0A0, 4'hF, v, q);
        acc0(1'b0, 13'd20, 32'hB1B1_B1B1, 4'hF, v, q);
        acc0(1'b0, 13'd7,  32'h1234_5678, 4'hF, v, q);
        acc0(1'b0, 13'd3,  32'h1122_3344, 4'hF, v, q);
        for (int i = 0; i < 8; i++)
            acc0(1'b0, 13'(40 + i), 32'h1000_0000 + 32'(i) * 32'h0101, 4'hF, v, q);

        // both requesters read continuously: grants alternate 0,1,0,1
        do_reset();
        cs_start = cs_cnt;
        req0_valid_i = 1'b1; req0_read_i = 1'b1; req0_addr_i = 13'd10;
        req1_valid_i = 1'b1; req1_read_i = 1'b1; req1_addr_i = 13'd20;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("alt_ready0_%0d", k), 32'(req0_ready_o), 32'((k % 2) == 0));
            check($sformatf("alt_ready1_%0d", k), 32'(req1_ready_o), 32'((k % 2) == 1));
            check($sformatf("alt_addr_%0d", k), 32'(ram_addr_o), (k % 2) == 0 ? 32'd10 : 32'd20);
            if (k == 0) begin
                check("alt_no_rsp0", 32'(rsp0_valid_o), 32'd0);
                check("alt_no_rsp1", 32'(rsp1_valid_o), 32'd0);
            end else if ((k % 2) == 1) begin
                check($sformatf("alt_rsp0_v_%0d", k), 32'(rsp0_valid_o), 32'd1);
                check($sformatf("alt_rsp1_v_%0d", k), 32'(rsp1_valid_o), 32'd0);
                check($sformatf("alt_rsp0_d_%0d", k), rsp0_rdata_o, 32'hA0A0_A0A0);
            end else begin
                check($sformatf("alt_rsp1_v_%0d", k), 32'(rsp1_valid_o), 32'd1);
                check($sformatf("alt_rsp0_v_%0d", k), 32'(rsp0_valid_o), 32'd0);
                check($sformatf("alt_rsp1_d_%0d", k), rsp1_rdata_o, 32'hB1B1_B1B1);
            end
            next_cycle();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk);
        check("alt_last_rsp1_v", 32'(rsp1_valid_o), 32'd1);
        check("alt_last_rsp1_d", rsp1_rdata_o, 32'hB1B1_B1B1);
        check("alt_cs_count", 32'(cs_cnt - cs_start), 32'd6);
        next_cycle();

        // stalled read of addr 7 for 4 cycles
        req0_valid_i = 1'b1; req0_read_i = 1'b1; req0_addr_i = 13'd7;
        rsp0_ready_i = 1'b0;
        @(negedge clk);
        check("stall_ready0", 32'(req0_ready_o), 32'd1);
        next_cycle();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_read_i = 1'b1; req1_addr_i = 13'd20; rsp1_ready_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check($sformatf("stall_v_%0d", s), 32'(rsp0_valid_o), 32'd1);
            check($sformatf("stall_d_%0d", s), rsp0_rdata_o, 32'h1234_5678);
            check($sformatf("stall_cs_%0d", s), 32'(ram_cs_o), 32'd0);
            check($sformatf("stall_r1_%0d", s), 32'(req1_ready_o), 32'd0);
            next_cycle();
        end
        rsp0_ready_i = 1'b1;
        @(negedge clk);
        check("stall_v_4", 32'(rsp0_valid_o), 32'd1);
        check("stall_d_4", rsp0_rdata_o, 32'h1234_5678);
        check("stall_release_r1", 32'(req1_ready_o), 32'd1);
        check("stall_release_addr", 32'(ram_addr_o), 32'd20);
        next_cycle();
        req1_valid_i = 1'b0;
        @(negedge clk);
        check("stall_after_v0", 32'(rsp0_valid_o), 32'd0);
        check("stall_after_v1", 32'(rsp1_valid_o), 32'd1);
        check("stall_after_d1", rsp1_rdata_o, 32'hB1B1_B1B1);
        next_cycle();
        idle_inputs();

        // partial and zero byte-mask writes
        acc0(1'b0, 13'd3, 32'hAABB_CCDD, 4'h5, v, q);
        check("mask_wr_v", 32'(v), 32'd1);
        acc0(1'b1, 13'd3, '0, '0, v, q);
        check("mask_rd_v", 32'(v), 32'd1);
        check("mask_rd_d", q, 32'h11BB_33DD);
        acc0(1'b0, 13'd3, 32'hFFFF_FFFF, 4'h0, v, q);
        check("zmask_wr_v", 32'(v), 32'd1);
        check("zmask_wr_d", q, 32'd0);
        acc0(1'b1, 13'd3, '0, '0, v, q);
        check("zmask_rd_d", q, 32'h11BB_33DD);

        // reset while a req1 response is outstanding
        req1_valid_i = 1'b1; req1_read_i = 1'b1; req1_addr_i = 13'd20; rsp1_ready_i = 1'b0;
        @(negedge clk);
        check("rst_mid_ready1", 32'(req1_ready_o), 32'd1);
        next_cycle();
        req1_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid_v1_before", 32'(rsp1_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_v1_drop", 32'(rsp1_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp1_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rst_post_v1_%0d", k), 32'(rsp1_valid_o), 32'd0);
            check($sformatf("rst_post_v0_%0d", k), 32'(rsp0_valid_o), 32'd0);
        end
        next_cycle();
        req0_valid_i = 1'b1; req0_read_i = 1'b1; req0_addr_i = 13'd10;
        req1_valid_i = 1'b1; req1_read_i = 1'b1; req1_addr_i = 13'd20;
        rsp0_ready_i = 1'b1;
        @(negedge clk);
        check("rst_tie_ready0", 32'(req0_ready_o), 32'd1);
        check("rst_tie_ready1", 32'(req1_ready_o), 32'd0);
        next_cycle();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk);
        check("rst_tie_rsp0_d", rsp0_rdata_o, 32'hA0A0_A0A0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        idle_inputs();

        // 8 back-to-back reads on req0
        req0_valid_i = 1'b1; req0_read_i = 1'b1; rsp0_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_addr_i = 13'(40 + i);
            @(negedge clk);
            check($sformatf("b2b_ready_%0d", i), 32'(req0_ready_o), 32'd1);
            if (i > 0) begin
                check($sformatf("b2b_v_%0d", i - 1), 32'(rsp0_valid_o), 32'd1);
                check($sformatf("b2b_d_%0d", i - 1), rsp0_rdata_o,
                      32'h1000_0000 + 32'(i - 1) * 32'h0101);
            end
            next_cycle();
        end
        req0_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_v_7", 32'(rsp0_valid_o), 32'd1);
        check("b2b_d_7", rsp0_rdata_o, 32'h1000_0707);
        next_cycle();
        @(negedge clk);
        check("b2b_done", 32'(rsp0_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
